// File: rtl/mono_rx_frame_merger.sv
// N-channel MONOPIX RX record merger: arbitrates record streams, slices each record into
// tagged 32-bit words and buffers whole frames in an output FIFO.
module mono_rx_frame_merger #(
    parameter int         NCH        = 4,
    parameter int         REC_WIDTH  = 111,
    parameter int         DEPTH      = 1024,
    parameter logic [1:0] IDENTYFIER = 2'b00
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic [NCH-1:0]           IN_EMPTY,
    input  logic [NCH*REC_WIDTH-1:0] IN_DATA,
    output logic [NCH-1:0]           IN_READ,
    input  logic [NCH-1:0]           CONF_CH_EN,
    input  logic                     CONF_RR,
    input  logic                     CONF_DROP,
    input  logic                     FIFO_READ,
    output logic                     FIFO_EMPTY,
    output logic [31:0]              FIFO_DATA,
    output logic [7:0]               LOST_CNT,
    output logic                     BUSY
);
    localparam int NWORDS = (REC_WIDTH + 25) / 26;
    localparam int EXT_W  = NWORDS * 26;
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW:0]     ROOM_MAX = (AW+1)'(DEPTH - NWORDS);
    localparam logic [KW-1:0]   K_LAST   = KW'(NWORDS - 1);
    localparam logic [CHW-1:0]  CH_LAST  = CHW'(NCH - 1);
    localparam logic [CHW:0]    NCH_W    = (CHW+1)'(NCH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [EXT_W-1:0] rec_q, rec_d;
    logic [2:0]     ch_q, ch_d;
    logic [KW-1:0]  k_q, k_d;
    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]     lost_q, lost_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    occ_q, occ_d;
    logic [31:0]    mem [DEPTH];

    logic [NCH-1:0]   req;
    logic             any_req;
    logic [2*NCH-1:0] req_rot;
    logic [CHW-1:0]   gnt_fix, gnt_off, gnt;
    logic [CHW:0]     gnt_sum;
    logic             fnd_fix, fnd_rr;
    logic [REC_WIDTH-1:0] head;
    logic [NCH-1:0]   in_read;
    logic             wr_en, do_rd, room;
    logic [31:0]      wr_word;

    // Arbitration: the request vector is rotated so the RR pointer lands on bit 0,
    // which turns round-robin into the same lowest-set search as fixed priority.
    always_comb begin
        req     = CONF_CH_EN & ~IN_EMPTY;
        any_req = |req;
        gnt_fix = '0;
        fnd_fix = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (req[i] && !fnd_fix) begin
                gnt_fix = CHW'(i);
                fnd_fix = 1'b1;
            end
        end
        req_rot = {req, req} >> rr_ptr_q;
        gnt_off = '0;
        fnd_rr  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (req_rot[i] && !fnd_rr) begin
                gnt_off = CHW'(i);
                fnd_rr  = 1'b1;
            end
        end
        gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
        if (gnt_sum >= NCH_W) gnt_sum = gnt_sum - NCH_W;
        gnt = CONF_RR ? gnt_sum[CHW-1:0] : gnt_fix;
        head = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == CHW'(i)) head = IN_DATA[i*REC_WIDTH +: REC_WIDTH];
        end
    end

    assign room = (occ_q <= ROOM_MAX);

    always_comb begin
        state_d  = state_q;
        rec_d    = rec_q;
        ch_d     = ch_q;
        k_d      = k_q;
        rr_ptr_d = rr_ptr_q;
        lost_d   = lost_q;
        in_read  = '0;
        wr_en    = 1'b0;
        wr_word  = {IDENTYFIER, ch_q, (k_q == '0), rec_q[EXT_W-1 -: 26]};
        case (state_q)
            ST_IDLE: begin
                if (any_req && (room || CONF_DROP)) begin
                    in_read[gnt] = 1'b1;
                    if (CONF_RR) rr_ptr_d = (gnt == CH_LAST) ? '0 : gnt + 1'b1;
                    if (room) begin
                        rec_d   = EXT_W'(head);
                        ch_d    = 3'(gnt);
                        k_d     = '0;
                        state_d = ST_EMIT;
                    end else if (lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            default: begin
                // Room for the whole frame was reserved in IDLE, so words go out unchecked.
                wr_en = 1'b1;
                rec_d = rec_q << 26;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        do_rd    = FIFO_READ && (occ_q != '0);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d    = occ_q;
        case ({wr_en, do_rd})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q  <= ST_IDLE;
            rec_q    <= '0;
            ch_q     <= '0;
            k_q      <= '0;
            rr_ptr_q <= '0;
            lost_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            rec_q    <= rec_d;
            ch_q     <= ch_d;
            k_q      <= k_d;
            rr_ptr_q <= rr_ptr_d;
            lost_q   <= lost_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (wr_en) mem[wr_ptr_q] <= wr_word;
    end

    assign IN_READ    = BUS_RST ? '0 : in_read;
    assign FIFO_EMPTY = (occ_q == '0);
    assign FIFO_DATA  = mem[rd_ptr_q];
    assign LOST_CNT   = lost_q;
    assign BUSY       = (state_q == ST_EMIT);

endmodule

// File: tb/tb_mono_rx_frame_merger.sv
// Directed bench for mono_rx_frame_merger: show-ahead source model per channel, output word
// capture, and per-scenario tasks with hand-computed expected words.
module tb_mono_rx_frame_merger;
    localparam int NCH = 4;
    localparam int RW  = 111;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST;
    logic [NCH-1:0]    IN_EMPTY;
    logic [NCH*RW-1:0] IN_DATA;
    logic [NCH-1:0]    IN_READ;
    logic [NCH-1:0]    CONF_CH_EN;
    logic              CONF_RR, CONF_DROP, FIFO_READ;
    logic              FIFO_EMPTY;
    logic [31:0]       FIFO_DATA;
    logic [7:0]        LOST_CNT;
    logic              BUSY;

    mono_rx_frame_merger #(.NCH(NCH), .REC_WIDTH(RW), .DEPTH(8), .IDENTYFIER(2'b00)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .IN_EMPTY(IN_EMPTY), .IN_DATA(IN_DATA),
        .IN_READ(IN_READ), .CONF_CH_EN(CONF_CH_EN), .CONF_RR(CONF_RR), .CONF_DROP(CONF_DROP),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .LOST_CNT(LOST_CNT), .BUSY(BUSY));

    always #5 BUS_CLK = ~BUS_CLK;

    logic [RW-1:0]  src [NCH][512];
    int             head_i [NCH];
    int             tail_i [NCH];
    logic [31:0]    wq [$];
    int             gq [$];
    logic [NCH-1:0] last_rd;
    int             multi_cnt;
    int             n_chk, n_fail;

    function automatic logic [RW-1:0] mkrec(input int v);
        return RW'(v);
    endfunction

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            IN_EMPTY[i] = (head_i[i] == tail_i[i]);
            IN_DATA[i*RW +: RW] = (head_i[i] < tail_i[i]) ? src[i][head_i[i]] : '0;
        end
    endtask

    task automatic push(input int ch, input logic [RW-1:0] rec);
        src[ch][tail_i[ch]] = rec;
        tail_i[ch]++;
        refresh();
    endtask

    // One clock: sample IN_READ / FIFO head late in the cycle, then apply pops after the edge.
    task automatic step();
        logic [NCH-1:0] r;
        logic           fr;
        logic [31:0]    fd;
        #1;
        r  = IN_READ;
        fr = FIFO_READ && !FIFO_EMPTY;
        fd = FIFO_DATA;
        @(posedge BUS_CLK);
        #1;
        if ($countones(r) > 1) multi_cnt++;
        for (int i = 0; i < NCH; i++) begin
            if (r[i]) begin
                head_i[i]++;
                gq.push_back(i);
            end
        end
        if (fr) wq.push_back(fd);
        last_rd = r;
        refresh();
    endtask

    task automatic steps(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic run_until(input int nwords, input int budget);
        for (int c = 0; c < budget && wq.size() < nwords; c++) step();
    endtask

    task automatic do_reset();
        BUS_RST = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            head_i[i] = 0;
            tail_i[i] = 0;
        end
        refresh();
        steps(2);
        BUS_RST = 1'b0;
        wq.delete();
        gq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", FIFO_EMPTY); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", BUSY); end
        n_chk++; if (LOST_CNT !== 8'h00) begin n_fail++; $display("FAIL reset_lost got %h want 00", LOST_CNT); end
        n_chk++; if (last_rd !== 4'b0000) begin n_fail++; $display("FAIL reset_in_read got %b want 0000", last_rd); end
    endtask

    task automatic test_word_format();
        logic [31:0]   exp1 [5];
        logic [31:0]   exp2 [5];
        logic [RW-1:0] ones;
        exp1 = '{32'h1400_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0001};
        exp2 = '{32'h0400_007F, 32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF, 32'h03FF_FFFF};
        ones = '1;
        FIFO_READ = 1'b0;
        push(2, mkrec(1));
        step();
        n_chk++; if (last_rd !== 4'b0100) begin n_fail++; $display("FAIL fmt_pop got %b want 0100", last_rd); end
        n_chk++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL fmt_busy got %b want 1", BUSY); end
        n_chk++; if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL fmt_lat1 empty got %b want 1", FIFO_EMPTY); end
        step();
        n_chk++; if (FIFO_EMPTY !== 1'b0) begin n_fail++; $display("FAIL fmt_lat2 empty got %b want 0", FIFO_EMPTY); end
        n_chk++; if (FIFO_DATA !== 32'h1400_0000) begin n_fail++; $display("FAIL fmt_head got %h want 14000000", FIFO_DATA); end
        steps(5);
        FIFO_READ = 1'b1;
        run_until(5, 20);
        n_chk++; if (wq.size() != 5) begin n_fail++; $display("FAIL fmt_count got %0d want 5", wq.size()); end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            n_chk++; if (wq[i] !== exp1[i]) begin n_fail++; $display("FAIL fmt_word%0d got %h want %h", i, wq[i], exp1[i]); end
        end
        wq.delete();
        push(0, ones);
        run_until(5, 30);
        n_chk++; if (wq.size() != 5) begin n_fail++; $display("FAIL ones_count got %0d want 5", wq.size()); end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            n_chk++; if (wq[i] !== exp2[i]) begin n_fail++; $display("FAIL ones_word%0d got %h want %h", i, wq[i], exp2[i]); end
        end
        FIFO_READ = 1'b0;
    endtask

    task automatic test_arbitration();
        logic [5:0]  w0;
        logic [25:0] pl;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            CONF_RR   = (pass == 0);
            FIFO_READ = 1'b1;
            for (int n = 0; n < 3; n++)
                for (int c = 0; c < NCH; c++) push(c, mkrec(c*16 + n));
            run_until(60, 200);
            n_chk++; if (gq.size() != 12) begin n_fail++; $display("FAIL arb%0d_pops got %0d want 12", pass, gq.size()); end
            n_chk++; if (wq.size() != 60) begin n_fail++; $display("FAIL arb%0d_words got %0d want 60", pass, wq.size()); end
            for (int f = 0; f < 12 && f < gq.size() && 5*f+4 < wq.size(); f++) begin
                int ch, n;
                ch = (pass == 0) ? f % 4 : f / 3;
                n  = (pass == 0) ? f / 4 : f % 3;
                w0 = {2'b00, 3'(ch), 1'b1};
                pl = 26'(ch*16 + n);
                n_chk++; if (gq[f] != ch) begin n_fail++; $display("FAIL arb%0d_grant%0d got %0d want %0d", pass, f, gq[f], ch); end
                n_chk++; if (wq[5*f][31:26] !== w0) begin n_fail++; $display("FAIL arb%0d_tag%0d got %h want %h", pass, f, wq[5*f][31:26], w0); end
                n_chk++; if (wq[5*f+4] !== {2'b00, 3'(ch), 1'b0, pl}) begin n_fail++; $display("FAIL arb%0d_last%0d got %h want %h", pass, f, wq[5*f+4], {2'b00, 3'(ch), 1'b0, pl}); end
            end
        end
        n_chk++; if (multi_cnt != 0) begin n_fail++; $display("FAIL onehot_read got %0d multi want 0", multi_cnt); end
        CONF_RR = 1'b1;
        FIFO_READ = 1'b0;
    endtask

    task automatic test_stall();
        logic [31:0] exp [10];
        exp = '{32'h0400_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0005,
                32'h0400_0000, 32'h0, 32'h0, 32'h0, 32'h0000_0006};
        do_reset();
        CONF_DROP = 1'b0;
        FIFO_READ = 1'b0;
        push(0, mkrec(5));
        push(0, mkrec(6));
        steps(12);
        n_chk++; if (gq.size() != 1) begin n_fail++; $display("FAIL stall_pops got %0d want 1", gq.size()); end
        n_chk++; if (last_rd !== 4'b0000) begin n_fail++; $display("FAIL stall_in_read got %b want 0000", last_rd); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL stall_busy got %b want 0", BUSY); end
        FIFO_READ = 1'b1;
        steps(2);
        FIFO_READ = 1'b0;
        steps(8);
        n_chk++; if (gq.size() != 2) begin n_fail++; $display("FAIL stall_resume got %0d want 2", gq.size()); end
        FIFO_READ = 1'b1;
        run_until(10, 40);
        n_chk++; if (wq.size() != 10) begin n_fail++; $display("FAIL stall_count got %0d want 10", wq.size()); end
        for (int i = 0; i < 10 && i < wq.size(); i++) begin
            n_chk++; if (wq[i] !== exp[i]) begin n_fail++; $display("FAIL stall_word%0d got %h want %h", i, wq[i], exp[i]); end
        end
        n_chk++; if (LOST_CNT !== 8'h00) begin n_fail++; $display("FAIL stall_lost got %h want 00", LOST_CNT); end
        FIFO_READ = 1'b0;
    endtask

    task automatic test_ch_en();
        logic [31:0] exp [5];
        int          eg [4];
        exp = '{32'h0C00_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0010};
        eg  = '{1, 3, 1, 3};
        do_reset();
        CONF_CH_EN = 4'b1010;
        CONF_RR    = 1'b1;
        FIFO_READ  = 1'b1;
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < NCH; c++) push(c, mkrec(c*16 + n));
        step();
        n_chk++; if (last_rd !== 4'b0010) begin n_fail++; $display("FAIL chen_first got %b want 0010", last_rd); end
        CONF_RR = 1'b0;
        steps(2);
        CONF_RR = 1'b1;
        run_until(20, 100);
        steps(10);
        n_chk++; if (gq.size() != 4) begin n_fail++; $display("FAIL chen_pops got %0d want 4", gq.size()); end
        for (int i = 0; i < 4 && i < gq.size(); i++) begin
            n_chk++; if (gq[i] != eg[i]) begin n_fail++; $display("FAIL chen_grant%0d got %0d want %0d", i, gq[i], eg[i]); end
        end
        n_chk++; if (head_i[0] != 0 || head_i[2] != 0) begin n_fail++; $display("FAIL chen_disabled got %0d/%0d want 0/0", head_i[0], head_i[2]); end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            n_chk++; if (wq[i] !== exp[i]) begin n_fail++; $display("FAIL chen_word%0d got %h want %h", i, wq[i], exp[i]); end
        end
        CONF_CH_EN = 4'b1111;
        FIFO_READ  = 1'b0;
    endtask

    task automatic test_drop();
        do_reset();
        CONF_DROP = 1'b1;
        FIFO_READ = 1'b0;
        for (int n = 0; n < 300; n++) push(1, mkrec(n + 1));
        steps(320);
        n_chk++; if (LOST_CNT !== 8'hFF) begin n_fail++; $display("FAIL drop_lost got %h want ff", LOST_CNT); end
        n_chk++; if (gq.size() != 300) begin n_fail++; $display("FAIL drop_pops got %0d want 300", gq.size()); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b want 0", BUSY); end
        FIFO_READ = 1'b1;
        steps(10);
        n_chk++; if (wq.size() != 5) begin n_fail++; $display("FAIL drop_words got %0d want 5", wq.size()); end
        n_chk++; if (wq.size() > 0 && wq[0] !== 32'h0C00_0000) begin n_fail++; $display("FAIL drop_w0 got %h want 0c000000", wq[0]); end
        n_chk++; if (wq.size() > 4 && wq[4] !== 32'h0800_0001) begin n_fail++; $display("FAIL drop_w4 got %h want 08000001", wq[4]); end
        n_chk++; if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL drop_empty got %b want 1", FIFO_EMPTY); end
        CONF_DROP = 1'b0;
        FIFO_READ = 1'b0;
    endtask

    // Runs straight after test_drop so LOST_CNT is still saturated when reset hits.
    task automatic test_reset_mid_frame();
        logic [31:0] exp [5];
        exp = '{32'h1C00_0000, 32'h1800_0000, 32'h1800_0000, 32'h1800_0000, 32'h1800_0009};
        wq.delete();
        FIFO_READ = 1'b0;
        push(3, mkrec(7));
        steps(3);
        n_chk++; if (BUSY !== 1'b1 || FIFO_EMPTY !== 1'b0) begin n_fail++; $display("FAIL mid_pre got busy=%b empty=%b want 1/0", BUSY, FIFO_EMPTY); end
        BUS_RST = 1'b1;
        step();
        n_chk++; if (FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL mid_empty got %b want 1", FIFO_EMPTY); end
        n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", BUSY); end
        n_chk++; if (LOST_CNT !== 8'h00) begin n_fail++; $display("FAIL mid_lost got %h want 00", LOST_CNT); end
        n_chk++; if (last_rd !== 4'b0000) begin n_fail++; $display("FAIL mid_in_read got %b want 0000", last_rd); end
        BUS_RST = 1'b0;
        step();
        n_chk++; if (last_rd !== 4'b0000 || FIFO_EMPTY !== 1'b1) begin n_fail++; $display("FAIL mid_after got rd=%b empty=%b want 0000/1", last_rd, FIFO_EMPTY); end
        push(3, mkrec(9));
        FIFO_READ = 1'b1;
        run_until(5, 30);
        steps(4);
        n_chk++; if (wq.size() != 5) begin n_fail++; $display("FAIL mid_count got %0d want 5", wq.size()); end
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            n_chk++; if (wq[i] !== exp[i]) begin n_fail++; $display("FAIL mid_word%0d got %h want %h", i, wq[i], exp[i]); end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; multi_cnt = 0;
        last_rd = '0;
        BUS_RST = 1'b1;
        CONF_CH_EN = 4'b1111;
        CONF_RR = 1'b1;
        CONF_DROP = 1'b0;
        FIFO_READ = 1'b0;
        IN_EMPTY = '1;
        IN_DATA = '0;
        test_reset();
        test_word_format();
        test_arbitration();
        test_stall();
        test_ch_en();
        test_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
